mem_wb_stage: RTL and testbench

- MEM/WB pipeline boundary register sitting directly downstream of the data memory.
- Consumes the word read from the DM read port, selects and extends the addressed byte or halfword per load type, and muxes the result against the ALU result.
- Registers the writeback bundle for the WB stage.
- Handles pipeline stall/flush, bubble insertion and misaligned-load detection.

---
 rtl/mem_wb_stage.sv | 146 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage -- MEM/WB pipeline boundary register.
//
// Takes the word from the data-memory read port, extracts and extends the
// addressed byte/halfword for the load type, muxes it against the ALU
// result and registers the writeback bundle for the WB stage. Handles
// stall (hold), flush (bubble), invalid entries (bubble) and misaligned
// loads (trap or force-align, selected by MISALIGN_TRAP).
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   stall, flush          hold / load bubble (flush wins)
//   in_valid, in_pc       MEM-stage valid and PC
//   in_reg_write          instruction writes the register file
//   in_mem_to_reg         writeback source is memory
//   in_wreg               destination register
//   in_alu_result         ALU result / effective address
//   in_load_type          0=LW 1=LH 2=LHU 3=LB 4=LBU, 5-7 act as LW
//   in_mem_rdata          word read from data memory
//   out_*                 registered WB-stage bundle
//   out_load_misalign     misaligned-load flag (one entry wide)
//   retire_cnt            retired-entry counter, present only when
//                         MEM_WB_RETIRE_CNT_EN is defined
module mem_wb_stage #(
  parameter logic [31:0] RESET_PC      = 32'h0000_3000,
  parameter int          MISALIGN_TRAP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic        in_reg_write,
  input  logic        in_mem_to_reg,
  input  logic [4:0]  in_wreg,
  input  logic [31:0] in_alu_result,
  input  logic [2:0]  in_load_type,
  input  logic [31:0] in_mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic        out_reg_write,
  output logic [4:0]  out_wreg,
  output logic [31:0] out_wb_data,
  output logic        out_load_misalign
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  localparam bit TRAP_EN = (MISALIGN_TRAP != 0);

  logic [1:0]  off;
  logic [1:0]  eff_off;
  logic        is_byte, is_half, is_signed;
  logic        misalign, trap;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;
  logic [31:0] wb_sel;

  assign off = in_alu_result[1:0];

  always_comb begin
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_signed = 1'b0;
    case (in_load_type)
      3'd1:    begin is_half = 1'b1; is_signed = 1'b1; end
      3'd2:    is_half = 1'b1;
      3'd3:    begin is_byte = 1'b1; is_signed = 1'b1; end
      3'd4:    is_byte = 1'b1;
      default: ;
    endcase
  end

  assign misalign = in_valid & in_mem_to_reg &
                    ((~is_byte & ~is_half & (|off)) | (is_half & off[0]));
  assign trap     = TRAP_EN & misalign;

  // Low offset bits are masked unconditionally: aligned accesses are
  // unaffected, and trapped accesses discard the data anyway.
  always_comb begin
    if (is_byte)      eff_off = off;
    else if (is_half) eff_off = {off[1], 1'b0};
    else              eff_off = 2'b00;
  end

  always_comb begin
    case (eff_off)
      2'd0:    byte_sel = in_mem_rdata[7:0];
      2'd1:    byte_sel = in_mem_rdata[15:8];
      2'd2:    byte_sel = in_mem_rdata[23:16];
      default: byte_sel = in_mem_rdata[31:24];
    endcase
  end

  assign half_sel = eff_off[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];

  always_comb begin
    if (is_byte)      ext_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
    else if (is_half) ext_data = {{16{is_signed & half_sel[15]}}, half_sel};
    else              ext_data = in_mem_rdata;
  end

  assign wb_sel = in_mem_to_reg ? ext_data : in_alu_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid         <= 1'b0;
      out_pc            <= RESET_PC;
      out_reg_write     <= 1'b0;
      out_wreg          <= 5'd0;
      out_wb_data       <= 32'd0;
      out_load_misalign <= 1'b0;
    end else if (flush || (!stall && !in_valid)) begin
      out_valid         <= 1'b0;
      out_pc            <= RESET_PC;
      out_reg_write     <= 1'b0;
      out_wreg          <= 5'd0;
      out_wb_data       <= 32'd0;
      out_load_misalign <= 1'b0;
    end else if (!stall) begin
      out_valid         <= 1'b1;
      out_pc            <= in_pc;
      // r0 is hardwired; a trapped load never reaches the register file.
      out_reg_write     <= in_reg_write & (|in_wreg) & ~trap;
      out_wreg          <= in_wreg;
      out_wb_data       <= trap ? 32'd0 : wb_sel;
      out_load_misalign <= trap;
    end
  end

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] cnt_q;

  // Counts every valid entry accepted, trapped loads included; wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            cnt_q <= 32'd0;
    else if (!flush && !stall && in_valid) cnt_q <= cnt_q + 32'd1;
  end

  assign retire_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
  localparam logic [31:0] RPC = 32'h0000_3000;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wb;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, in_reg_write = 1'b0, in_mem_to_reg = 1'b0;
  logic [31:0] in_pc = '0, in_alu_result = '0, in_mem_rdata = '0;
  logic [4:0]  in_wreg = '0;
  logic [2:0]  in_load_type = '0;

  logic        v1, rw1, mis1, v0, rw0, mis0;
  logic [31:0] pc1, wb1, pc0, wb0;
  logic [4:0]  wr1, wr0;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] cnt1, cnt0;
`endif

  always #5 clk = ~clk;

  mem_wb_stage #(.RESET_PC(RPC), .MISALIGN_TRAP(1)) u_t1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_reg_write(in_reg_write),
    .in_mem_to_reg(in_mem_to_reg), .in_wreg(in_wreg),
    .in_alu_result(in_alu_result), .in_load_type(in_load_type),
    .in_mem_rdata(in_mem_rdata),
    .out_valid(v1), .out_pc(pc1), .out_reg_write(rw1), .out_wreg(wr1),
    .out_wb_data(wb1), .out_load_misalign(mis1)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .retire_cnt(cnt1)
`endif
  );

  mem_wb_stage #(.RESET_PC(RPC), .MISALIGN_TRAP(0)) u_t0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_reg_write(in_reg_write),
    .in_mem_to_reg(in_mem_to_reg), .in_wreg(in_wreg),
    .in_alu_result(in_alu_result), .in_load_type(in_load_type),
    .in_mem_rdata(in_mem_rdata),
    .out_valid(v0), .out_pc(pc0), .out_reg_write(rw0), .out_wreg(wr0),
    .out_wb_data(wb0), .out_load_misalign(mis0)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .retire_cnt(cnt0)
`endif
  );

  int   tests = 0, fails = 0;
  exp_t q1[$], q0[$];
  exp_t m1, m0;
  logic [31:0] mcnt;

  function automatic exp_t bubble();
    exp_t e = '0;
    e.pc = RPC;
    return e;
  endfunction

  // Reference: next WB bundle from the current inputs and the spec's rules.
  function automatic exp_t model(input bit trap, input exp_t prev);
    exp_t e = bubble();
    int size, off, a;
    logic [31:0] val, mask;
    bit mis;
    if (flush) return e;
    if (stall) return prev;
    if (!in_valid) return e;
    size = (in_load_type == 3 || in_load_type == 4) ? 1 :
           (in_load_type == 1 || in_load_type == 2) ? 2 : 4;
    off  = int'(in_alu_result[1:0]);
    mis  = in_mem_to_reg && (off % size != 0);
    e.v  = 1'b1;
    e.pc = in_pc;
    e.wr = in_wreg;
    if (mis && trap) begin
      e.mis = 1'b1;
      return e;
    end
    a    = (off / size) * size;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
    val  = (in_mem_rdata >> (8 * a)) & mask;
    if ((in_load_type == 1 || in_load_type == 3) && val[8 * size - 1])
      val = val | ~mask;
    e.wb = in_mem_to_reg ? val : in_alu_result;
    e.rw = in_reg_write && (in_wreg != 5'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp(input string name, input exp_t e, input exp_t a);
    tests++;
    if ({a.v, a.pc, a.rw, a.wr, a.wb, a.mis} !== {e.v, e.pc, e.rw, e.wr, e.wb, e.mis}
`ifdef MEM_WB_RETIRE_CNT_EN
        || a.cnt !== e.cnt
`endif
       ) begin
      fails++;
      $display("FAIL %s: got v=%b pc=%h rw=%b wr=%0d wb=%h mis=%b cnt=%h expected v=%b pc=%h rw=%b wr=%0d wb=%h mis=%b cnt=%h",
               name, a.v, a.pc, a.rw, a.wr, a.wb, a.mis, a.cnt,
               e.v, e.pc, e.rw, e.wr, e.wb, e.mis, e.cnt);
    end
  endtask

  // Monitor: one expected bundle per edge, checked away from the edge.
  exp_t e1, e0, a1, a0;
  always @(negedge clk) begin
    if (rst_n) begin
      a1 = '{v1, pc1, rw1, wr1, wb1, mis1, 32'd0};
      a0 = '{v0, pc0, rw0, wr0, wb0, mis0, 32'd0};
`ifdef MEM_WB_RETIRE_CNT_EN
      a1.cnt = cnt1;
      a0.cnt = cnt0;
`endif
      if (q1.size() > 0) begin e1 = q1.pop_front(); cmp("trap1", e1, a1); end
      if (q0.size() > 0) begin e0 = q0.pop_front(); cmp("trap0", e0, a0); end
    end
  end

  task automatic step(input bit stl, input bit fl, input bit v, input logic [31:0] pc,
                      input bit rw, input bit m2r, input logic [4:0] wr,
                      input logic [31:0] alu, input logic [2:0] lt, input logic [31:0] rd);
    stall = stl; flush = fl; in_valid = v; in_pc = pc; in_reg_write = rw;
    in_mem_to_reg = m2r; in_wreg = wr; in_alu_result = alu; in_load_type = lt;
    in_mem_rdata = rd;
    m1 = model(1'b1, m1);
    m0 = model(1'b0, m0);
    if (!fl && !stl && v) mcnt = mcnt + 32'd1;
    m1.cnt = mcnt;
    m0.cnt = mcnt;
    q1.push_back(m1);
    q0.push_back(m0);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic reset_model();
    m1 = bubble(); m0 = bubble(); mcnt = 32'd0;
  endtask

  localparam logic [31:0] RD = 32'h80FF_7F01;
  logic [31:0] base;

  initial begin
    reset_model();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc", pc1, RPC);
    chk("rst_valid", {31'd0, v1}, 32'd0);
    rst_n = 1'b1;
    step(0, 0, 0, 32'h100, 1, 1, 5'd7, 32'h4, 3'd0, RD);
    step(0, 0, 0, 32'h104, 1, 0, 5'd7, 32'h8, 3'd0, RD);
    chk("bubble_pc", pc1, RPC);

    step(0, 0, 1, 32'h200, 1, 1, 5'd3, 32'h102, 3'd3, RD);
    chk("lb_off2", wb1, 32'hFFFF_FFFF);
    step(0, 0, 1, 32'h204, 1, 1, 5'd3, 32'h103, 3'd4, RD);
    chk("lbu_off3", wb1, 32'h0000_0080);
    step(0, 0, 1, 32'h208, 1, 1, 5'd3, 32'h101, 3'd3, RD);
    chk("lb_off1", wb1, 32'h0000_007F);
    step(0, 0, 1, 32'h20C, 1, 1, 5'd4, 32'h102, 3'd1, RD);
    chk("lh_off2", wb1, 32'hFFFF_80FF);
    step(0, 0, 1, 32'h210, 1, 1, 5'd4, 32'h100, 3'd2, RD);
    chk("lhu_off0", wb1, 32'h0000_7F01);
    step(0, 0, 1, 32'h214, 1, 1, 5'd4, 32'h100, 3'd0, RD);
    chk("lw_off0", wb1, 32'h80FF_7F01);
    step(0, 0, 1, 32'h218, 1, 0, 5'd4, 32'h1234, 3'd0, RD);
    chk("alu_path", wb1, 32'h0000_1234);

    step(0, 0, 1, 32'h21C, 1, 1, 5'd6, 32'h6, 3'd0, RD);
    chk("lw_mis_flag1", {31'd0, mis1}, 32'd1);
    chk("lw_mis_rw1", {31'd0, rw1}, 32'd0);
    chk("lw_mis_wb0", wb0, RD);
    chk("lw_mis_flag0", {31'd0, mis0}, 32'd0);
    step(0, 0, 1, 32'h220, 1, 1, 5'd6, 32'h101, 3'd1, RD);
    chk("lw_mis_one_cycle", {31'd0, mis1}, 32'd1);
    chk("lh_mis_wb0", wb0, 32'h0000_7F01);
    step(0, 0, 1, 32'h224, 1, 0, 5'd6, 32'h55, 3'd0, RD);
    chk("mis_cleared", {31'd0, mis1}, 32'd0);

    step(0, 0, 1, 32'h300, 1, 1, 5'd5, 32'h100, 3'd0, RD);
    for (int i = 0; i < 3; i++)
      step(1, 0, $urandom_range(0, 1), $urandom, 1, 1, 5'($urandom), $urandom, 3'd0, $urandom);
    chk("stall_wreg", {27'd0, wr1}, 32'd5);
    chk("stall_pc", pc1, 32'h300);
    step(1, 1, 1, 32'h304, 1, 1, 5'd9, 32'h100, 3'd0, RD);
    chk("flush_pc", pc1, RPC);
    step(0, 0, 1, 32'h308, 1, 0, 5'd0, 32'hABCD, 3'd0, RD);
    chk("r0_rw", {31'd0, rw1}, 32'd0);
    chk("r0_wb", wb1, 32'h0000_ABCD);

`ifdef MEM_WB_RETIRE_CNT_EN
    base = mcnt;
    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 32'h400 + 32'(4 * i), 1, 1, 5'd2, 32'h100, 3'd0, RD);
    step(1, 0, 1, 32'h410, 1, 1, 5'd2, 32'h100, 3'd0, RD);
    step(0, 1, 1, 32'h414, 1, 1, 5'd2, 32'h100, 3'd0, RD);
    step(0, 0, 0, 32'h418, 1, 1, 5'd2, 32'h100, 3'd0, RD);
    chk("retire_4", cnt1 - base, 32'd4);
    force u_t1.cnt_q = 32'hFFFF_FFFF;
    force u_t0.cnt_q = 32'hFFFF_FFFF;
    #1;
    release u_t1.cnt_q;
    release u_t0.cnt_q;
    mcnt = 32'hFFFF_FFFF;
    step(0, 0, 1, 32'h41C, 1, 1, 5'd2, 32'h100, 3'd0, RD);
    chk("retire_wrap", cnt1, 32'd0);
`endif

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 2, $urandom_range(0, 11) == 0, ($urandom % 4) != 0,
           $urandom, $urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom),
           $urandom, 3'($urandom_range(0, 7)), $urandom);

    // Asynchronous reset in the middle of a stalled cycle.
    stall = 1'b1; in_valid = 1'b1; in_pc = 32'h500; in_wreg = 5'd8;
    in_reg_write = 1'b1; in_mem_to_reg = 1'b0; in_alu_result = 32'h77;
    flush = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    q1.delete();
    q0.delete();
    #1;
    chk("async_rst_pc", pc1, RPC);
    chk("async_rst_bundle", {26'd0, v1, rw1, mis1, wr1 != 5'd0, wb1 != 32'd0, pc0 != RPC}, 32'd0);
`ifdef MEM_WB_RETIRE_CNT_EN
    chk("async_rst_cnt", cnt1, 32'd0);
`endif
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    reset_model();
    step(0, 0, 0, 32'h600, 1, 1, 5'd3, 32'h100, 3'd0, RD);
    step(0, 0, 1, 32'h604, 1, 1, 5'd3, 32'h103, 3'd3, RD);
    chk("post_rst_lb", wb1, 32'hFFFF_FF80);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
